// File: rtl/stream_spatial_filter.sv
// Purpose: streaming MASK_WIDTH x MASK_WIDTH convolution over one raster frame with zero-padded borders.
// Latency: 3 cycles from the beat that completes a window to pix_out_valid (product, adder tree, shift/saturate).
// Backpressure: none; beats are taken whenever data_in_valid is high, beats arriving during the flush tail are dropped.
// Ports: clk; reset_in (async, active-low); data_in_valid/data_in/data_id (data_id=1 coefficient, 0 pixel);
//        pix_out_valid/pix_out (signed PIX_BIT+1 filtered pixel, one-cycle pulse per output).
// Build option: define FILTER_ROUND_EN to add half an LSB before the final shift (round half up).
module stream_spatial_filter #(
    parameter int DATA_BIT   = 15,
    parameter int DATA_IDBIT = 1,
    parameter int ROW_WIDTH  = 100,
    parameter int COL_WIDTH  = 100,
    parameter int MASK_WIDTH = 7,
    parameter int CNT_BIT    = 7,
    parameter int COFCNT_BIT = 15,
    parameter int PIX_BIT    = 8
) (
    input  logic                    clk,
    input  logic                    reset_in,
    input  logic                    data_in_valid,
    input  logic [DATA_BIT-1:0]     data_in,
    input  logic [DATA_IDBIT-1:0]   data_id,
    output logic                    pix_out_valid,
    output logic signed [PIX_BIT:0] pix_out
);
    localparam int R         = (MASK_WIDTH - 1) / 2;
    localparam int TAPS      = MASK_WIDTH * MASK_WIDTH;
    localparam int LINE_LEN  = (MASK_WIDTH - 1) * COL_WIDTH + MASK_WIDTH - 1;
    localparam int FLUSH_LEN = R * COL_WIDTH + R;
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);
    localparam int PTR_W     = $clog2(TAPS + 1);
    localparam int PROD_W    = PIX_BIT + COFCNT_BIT + 1;
    localparam int ACC_W     = PROD_W + $clog2(TAPS);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** PIX_BIT - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** PIX_BIT));
`ifdef FILTER_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND_ADD = ACC_W'(2 ** (COFCNT_BIT - 2));
`else
    localparam logic signed [ACC_W-1:0] RND_ADD = '0;
`endif

    // ST_LOAD takes both coefficient and pixel beats; ST_FLUSH feeds zero beats to drain the last R rows.
    typedef enum logic {ST_LOAD, ST_FLUSH} state_t;

    state_t                         state_q, state_d;
    logic [PTR_W-1:0]               ptr_q, ptr_d;
    logic signed [COFCNT_BIT-1:0]   coef_q [TAPS];
    logic signed [COFCNT_BIT-1:0]   coef_d [TAPS];
    logic [CNT_BIT-1:0]             in_row_q, in_row_d, in_col_q, in_col_d;
    logic [CNT_BIT-1:0]             ctr_row_q, ctr_row_d, ctr_col_q, ctr_col_d;
    logic [FL_W-1:0]                flush_cnt_q, flush_cnt_d;
    logic [PIX_BIT-1:0]             line_q [LINE_LEN];
    logic [PIX_BIT-1:0]             line_d [LINE_LEN];
    logic signed [PROD_W-1:0]       prod_q [TAPS];
    logic signed [PROD_W-1:0]       prod_d [TAPS];
    logic                           vld1_q, vld1_d, vld2_q, vld2_d, vld3_q, vld3_d;
    logic signed [ACC_W-1:0]        acc_q, acc_d;
    logic signed [PIX_BIT:0]        pix_out_q, pix_out_d;

    logic                           is_coef, is_pix, beat, primed, win_vld;
    logic [PIX_BIT-1:0]             new_pix;
    logic signed [ACC_W-1:0]        rnd, shifted;
    logic [TAPS-1:0]                tap_ok;
    logic [TAPS-1:0][PIX_BIT-1:0]   tap_pix;

    always_comb begin
        is_coef = data_in_valid && (state_q == ST_LOAD) && (data_id == DATA_IDBIT'(1));
        is_pix  = data_in_valid && (state_q == ST_LOAD) && (data_id == '0);
        beat    = is_pix || (state_q == ST_FLUSH);
        new_pix = is_pix ? data_in[PIX_BIT-1:0] : '0;
        // A window is complete once the stream is R rows and R columns past its centre.
        primed  = (state_q == ST_FLUSH) || (in_row_q > CNT_BIT'(R)) ||
                  ((in_row_q == CNT_BIT'(R)) && (in_col_q >= CNT_BIT'(R)));
        win_vld = beat && primed;
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        coef_d      = coef_q;
        in_row_d    = in_row_q;
        in_col_d    = in_col_q;
        ctr_row_d   = ctr_row_q;
        ctr_col_d   = ctr_col_q;
        flush_cnt_d = flush_cnt_q;
        line_d      = line_q;

        if (is_coef && (ptr_q < PTR_W'(TAPS))) begin
            coef_d[ptr_q] = data_in[COFCNT_BIT-1:0];
            ptr_d         = ptr_q + PTR_W'(1);
        end
        if (is_pix) begin
            ptr_d = '0;
            if (in_col_q == CNT_BIT'(COL_WIDTH - 1)) begin
                in_col_d = '0;
                if (in_row_q == CNT_BIT'(ROW_WIDTH - 1)) begin
                    in_row_d = '0;
                    state_d  = ST_FLUSH;
                end else begin
                    in_row_d = in_row_q + CNT_BIT'(1);
                end
            end else begin
                in_col_d = in_col_q + CNT_BIT'(1);
            end
        end
        if (state_q == ST_FLUSH) begin
            if (flush_cnt_q == FL_W'(FLUSH_LEN - 1)) begin
                flush_cnt_d = '0;
                state_d     = ST_LOAD;
            end else begin
                flush_cnt_d = flush_cnt_q + FL_W'(1);
            end
        end
        // Centre counters wrap back to (0,0) on the last flush beat of the frame.
        if (win_vld) begin
            if (ctr_col_q == CNT_BIT'(COL_WIDTH - 1)) begin
                ctr_col_d = '0;
                ctr_row_d = (ctr_row_q == CNT_BIT'(ROW_WIDTH - 1)) ? '0 : ctr_row_q + CNT_BIT'(1);
            end else begin
                ctr_col_d = ctr_col_q + CNT_BIT'(1);
            end
        end
        if (beat) begin
            line_d[0] = new_pix;
            for (int j = 1; j < LINE_LEN; j++) line_d[j] = line_q[j-1];
        end
    end

    // Tap i sits at window offset (DR,DC); its pixel is SI beats older than the incoming one.
    // Offsets falling outside the frame (including across a line edge) are masked to zero.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
        localparam int DR = gi / MASK_WIDTH - R;
        localparam int DC = gi % MASK_WIDTH - R;
        localparam int SI = (R - DR) * COL_WIDTH + (R - DC);
        logic row_ok, col_ok;
        if (DR < 0) begin : g_row_lo
            assign row_ok = (ctr_row_q >= CNT_BIT'(-DR));
        end else begin : g_row_hi
            assign row_ok = (ctr_row_q < CNT_BIT'(ROW_WIDTH - DR));
        end
        if (DC < 0) begin : g_col_lo
            assign col_ok = (ctr_col_q >= CNT_BIT'(-DC));
        end else begin : g_col_hi
            assign col_ok = (ctr_col_q < CNT_BIT'(COL_WIDTH - DC));
        end
        if (SI == 0) begin : g_new
            assign tap_pix[gi] = new_pix;
        end else begin : g_old
            assign tap_pix[gi] = line_q[SI-1];
        end
        assign tap_ok[gi] = row_ok & col_ok;
    end

    always_comb begin
        vld1_d = win_vld;
        for (int i = 0; i < TAPS; i++) begin
            prod_d[i] = tap_ok[i] ?
                PROD_W'(coef_q[i]) * PROD_W'($signed({1'b0, tap_pix[i]})) : '0;
        end
    end

    always_comb begin
        vld2_d = vld1_q;
        acc_d  = '0;
        for (int i = 0; i < TAPS; i++) acc_d = acc_d + ACC_W'(prod_q[i]);
    end

    always_comb begin
        vld3_d    = vld2_q;
        pix_out_d = pix_out_q;
        rnd       = acc_q + RND_ADD;
        shifted   = rnd >>> (COFCNT_BIT - 1);
        if (vld2_q) begin
            if (shifted > SAT_HI)      pix_out_d = SAT_HI[PIX_BIT:0];
            else if (shifted < SAT_LO) pix_out_d = SAT_LO[PIX_BIT:0];
            else                       pix_out_d = shifted[PIX_BIT:0];
        end
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            in_row_q    <= '0;
            in_col_q    <= '0;
            ctr_row_q   <= '0;
            ctr_col_q   <= '0;
            flush_cnt_q <= '0;
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            vld3_q      <= 1'b0;
            acc_q       <= '0;
            pix_out_q   <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef_q[i] <= '0;
                prod_q[i] <= '0;
            end
            for (int j = 0; j < LINE_LEN; j++) line_q[j] <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            in_row_q    <= in_row_d;
            in_col_q    <= in_col_d;
            ctr_row_q   <= ctr_row_d;
            ctr_col_q   <= ctr_col_d;
            flush_cnt_q <= flush_cnt_d;
            vld1_q      <= vld1_d;
            vld2_q      <= vld2_d;
            vld3_q      <= vld3_d;
            acc_q       <= acc_d;
            pix_out_q   <= pix_out_d;
            coef_q      <= coef_d;
            prod_q      <= prod_d;
            line_q      <= line_d;
        end
    end

    assign pix_out_valid = vld3_q;
    assign pix_out       = pix_out_q;

endmodule

// File: tb/tb_stream_spatial_filter.sv
// Purpose: directed self-checking bench for stream_spatial_filter on a 100x100 frame.
// Latency: outputs collected on the falling edge; first output expected 3 cycles after pixel 303 is driven.
// Backpressure: none in the DUT; the bench inserts idle cycles to exercise stalls.
module tb_stream_spatial_filter;
    localparam int W = 100;
    localparam int H = 100;
    localparam int NPIX = W * H;
    localparam int EMPTY = -9999;
`ifdef FILTER_ROUND_EN
    localparam int E_INT = 100, E_CORNER = 33, E_EDGE = 57, E_11 = 51, E_250 = 86, RAMP_ADJ = 0;
`else
    localparam int E_INT = 99,  E_CORNER = 32, E_EDGE = 57, E_11 = 50, E_250 = 85, RAMP_ADJ = 1;
`endif

    logic                clk = 1'b0;
    logic                reset_in;
    logic                data_in_valid;
    logic [14:0]         data_in;
    logic [0:0]          data_id;
    logic                pix_out_valid;
    logic signed [8:0]   pix_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int out_cnt = 0;
    int extra_out = 0;
    int first_out_cyc = 0;
    int last_out_cyc = 0;
    int drive_303 = 0;
    int out_mem [NPIX];
    int ref_mem [NPIX];

    stream_spatial_filter dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .data_in_valid (data_in_valid),
        .data_in       (data_in),
        .data_id       (data_id),
        .pix_out_valid (pix_out_valid),
        .pix_out       (pix_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (pix_out_valid) begin
            if (out_cnt == 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            if (out_cnt < NPIX) out_mem[out_cnt] = int'(pix_out);
            else extra_out++;
            out_cnt++;
        end
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic send_beat(input logic is_coef, input int v);
        @(negedge clk);
        data_in_valid = 1'b1;
        data_id       = is_coef;
        data_in       = 15'(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_in_valid = 1'b0;
        end
    endtask

    function automatic int pix_at(input int pat, input int val, input int r, input int c);
        if (pat == 1) return (r + c) % 256;
        return val;
    endfunction

    function automatic int at(input int r, input int c);
        return out_mem[r * W + c];
    endfunction

    task automatic frame_start();
        out_cnt   = 0;
        extra_out = 0;
        for (int i = 0; i < NPIX; i++) out_mem[i] = EMPTY;
    endtask

    task automatic send_frame(input int pat, input int val, input bit tog, input int npix);
        for (int k = 0; k < npix; k++) begin
            send_beat(1'b0, pix_at(pat, val, k / W, k % W));
            if (k == 303) drive_303 = cyc;
            if (tog) idle(1);
        end
        idle(1);
    endtask

    task automatic wait_frame(input string tag);
        int t0;
        t0 = cyc;
        while (out_cnt < NPIX && (cyc - t0) < 2000) @(negedge clk);
        idle(10);
        check_eq({tag, " count"}, out_cnt, NPIX);
    endtask

    initial begin
        int bad;
        reset_in      = 1'b0;
        data_in_valid = 1'b0;
        data_in       = '0;
        data_id       = '0;
        idle(3);
        check_eq("reset valid", int'(pix_out_valid), 0);
        check_eq("reset pix", int'(pix_out), 0);
        reset_in = 1'b1;
        idle(2);

        // Constant 100 frame, all coefficients 334.
        for (int i = 0; i < 49; i++) send_beat(1'b1, 334);
        frame_start();
        send_frame(0, 100, 1'b0, NPIX);
        wait_frame("const");
        check_eq("const latency", first_out_cyc - drive_303, 3);
        check_eq("const no gaps", last_out_cyc - first_out_cyc, NPIX - 1);
        check_eq("const (0,0)", at(0, 0), E_CORNER);
        check_eq("const (0,50)", at(0, 50), E_EDGE);
        check_eq("const (50,50)", at(50, 50), E_INT);
        check_eq("const (1,1)", at(1, 1), E_11);
        check_eq("const (2,50)", at(2, 50), E_250);
        check_eq("const (99,99)", at(99, 99), E_CORNER);
        check_eq("const (99,0)", at(99, 0), E_CORNER);
        check_eq("const (0,99)", at(0, 99), E_CORNER);
        bad = 0;
        for (int r = 3; r < H - 3; r++)
            for (int c = 3; c < W - 3; c++)
                if (at(r, c) != E_INT) bad++;
        check_eq("const interior bad", bad, 0);
        for (int i = 0; i < NPIX; i++) ref_mem[i] = out_mem[i];

        // Extra 50th coefficient write, then the same frame with valid toggled.
        for (int i = 0; i < 49; i++) send_beat(1'b1, 334);
        send_beat(1'b1, 0);
        frame_start();
        send_frame(0, 100, 1'b1, NPIX);
        wait_frame("toggle");
        check_eq("toggle latency", first_out_cyc - drive_303, 3);
        check_eq("toggle (0,0)", at(0, 0), E_CORNER);
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (out_mem[i] != ref_mem[i]) bad++;
        check_eq("toggle vs continuous bad", bad, 0);
        check_eq("toggle extra outputs", extra_out, 0);

        // Near-identity mask over a ramp frame.
        for (int i = 0; i < 49; i++) send_beat(1'b1, (i == 24) ? 16383 : 0);
        frame_start();
        send_frame(1, 0, 1'b0, NPIX);
        wait_frame("ramp");
        check_eq("ramp (0,0)", at(0, 0), 0);
        check_eq("ramp (0,1)", at(0, 1), 1 - RAMP_ADJ);
        check_eq("ramp (10,20)", at(10, 20), 30 - RAMP_ADJ);
        check_eq("ramp (99,99)", at(99, 99), 198 - RAMP_ADJ);
        bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                int p;
                p = (r + c) % 256;
                if (at(r, c) != ((p == 0) ? 0 : p - RAMP_ADJ)) bad++;
            end
        check_eq("ramp bad", bad, 0);

        // Single negative tap at offset (-3,-3), constant 255.
        for (int i = 0; i < 49; i++) send_beat(1'b1, (i == 0) ? -16384 : 0);
        frame_start();
        send_frame(0, 255, 1'b0, NPIX);
        wait_frame("neg");
        check_eq("neg (0,0)", at(0, 0), 0);
        check_eq("neg (2,50)", at(2, 50), 0);
        check_eq("neg (50,2)", at(50, 2), 0);
        check_eq("neg (3,3)", at(3, 3), -255);
        check_eq("neg (99,99)", at(99, 99), -255);
        bad = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (at(r, c) != ((r >= 3 && c >= 3) ? -255 : 0)) bad++;
        check_eq("neg bad", bad, 0);

        // Saturating mask, aborted by reset mid-frame.
        for (int i = 0; i < 49; i++) send_beat(1'b1, 16383);
        frame_start();
        send_frame(0, 255, 1'b0, 400);
        #2;
        check_eq("sat valid before reset", int'(pix_out_valid), 1);
        data_in_valid = 1'b0;
        reset_in      = 1'b0;
        #1;
        check_eq("midreset valid", int'(pix_out_valid), 0);
        check_eq("midreset pix", int'(pix_out), 0);
        check_eq("sat count", out_cnt, 95);
        check_eq("sat (0,0)", at(0, 0), 255);
        bad = 0;
        for (int i = 0; i < out_cnt && i < NPIX; i++) if (out_mem[i] != 255) bad++;
        check_eq("sat bad", bad, 0);
        idle(2);
        reset_in = 1'b1;
        idle(2);

        // After reset the coefficients are cleared, so every output is zero.
        frame_start();
        send_frame(0, 255, 1'b0, 400);
        idle(10);
        check_eq("post-reset count", out_cnt, 97);
        bad = 0;
        for (int i = 0; i < out_cnt && i < NPIX; i++) if (out_mem[i] != 0) bad++;
        check_eq("post-reset nonzero", bad, 0);
        reset_in = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
